// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the sequence detectors it drives.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Reference pattern recognised by seq_det_101
  localparam logic [2:0] PAT_101     = 3'b101;
  localparam int         PAT_101_LEN = 3;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register. Load left-aligns din[len-1:0] and
// emits its top bit on the same edge; dout is registered and idles at IDLE_BIT.
module seq_piso #(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = $clog2(PAT_W) + 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] din,
  output logic             dout
);

  logic [PAT_W-1:0] sr;
  logic [PAT_W-1:0] aligned;
  logic [LEN_W-1:0] shamt;

  assign shamt   = LEN_W'(PAT_W) - len;
  assign aligned = din << shamt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr   <= '0;
      dout <= IDLE_BIT;
    end else if (load) begin
      dout <= aligned[PAT_W-1];
      sr   <= aligned << 1;
    end else if (shift) begin
      dout <= sr[PAT_W-1];
      sr   <= sr << 1;
    end else begin
      dout <= IDLE_BIT;
    end
  end

endmodule

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: sends pattern[pat_len-1:0] MSB-first repeat_n+1 times.
// Define SEQ_GEN_GAP_EN to add gap_n idle cycles between repetitions.
module seq_gen_serial
  import seq_pkg::*;
#(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = $clog2(PAT_W) + 1,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] repeat_n,
`ifdef SEQ_GEN_GAP_EN
  input  logic [CNT_W-1:0] gap_n,
`endif
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  seq_state_t       state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] len_q, len_n, idx, idx_n, load_len;
  logic [CNT_W-1:0] rep_left, rep_n;
  logic [PAT_W-1:0] load_pat;
  logic             load, shift, vld_n, busy_n, done_n, len_ok;
`ifdef SEQ_GEN_GAP_EN
  logic [CNT_W-1:0] gap_q, gap_qn, gap_left, gap_left_n;
`endif

  assign len_ok = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));

  always_comb begin
    state_n  = state;
    pat_n    = pat_q;
    len_n    = len_q;
    idx_n    = idx;
    rep_n    = rep_left;
    load     = 1'b0;
    shift    = 1'b0;
    load_pat = pat_q;
    load_len = len_q;
    vld_n    = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    gap_qn     = gap_q;
    gap_left_n = gap_left;
`endif
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start && len_ok) begin
          state_n  = SHIFT;
          load     = 1'b1;
          load_pat = pattern;
          load_len = pat_len;
          pat_n    = pattern;
          len_n    = pat_len;
          idx_n    = pat_len - LEN_W'(1);
          rep_n    = repeat_n;
          vld_n    = 1'b1;
          busy_n   = 1'b1;
`ifdef SEQ_GEN_GAP_EN
          gap_qn   = gap_n;
`endif
        end
      end
      SHIFT: begin
        if (idx != '0) begin
          shift = 1'b1;
          idx_n = idx - LEN_W'(1);
          vld_n = 1'b1;
        end else if (rep_left != '0) begin
          rep_n = rep_left - CNT_W'(1);
`ifdef SEQ_GEN_GAP_EN
          if (gap_q != '0) begin
            state_n    = GAP;
            gap_left_n = gap_q - CNT_W'(1);
          end else
`endif
          begin
            load  = 1'b1;
            idx_n = len_q - LEN_W'(1);
            vld_n = 1'b1;
          end
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        if (gap_left == '0) begin
          state_n = SHIFT;
          load    = 1'b1;
          idx_n   = len_q - LEN_W'(1);
          vld_n   = 1'b1;
        end else begin
          gap_left_n = gap_left - CNT_W'(1);
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      rep_left  <= '0;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_q     <= '0;
      gap_left  <= '0;
`endif
    end else begin
      state     <= state_n;
      pat_q     <= pat_n;
      len_q     <= len_n;
      idx       <= idx_n;
      rep_left  <= rep_n;
      seq_valid <= vld_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef SEQ_GEN_GAP_EN
      gap_q     <= gap_qn;
      gap_left  <= gap_left_n;
`endif
    end
  end

  // seq_out comes straight from the shift register's output flop
  seq_piso #(
    .PAT_W   (PAT_W),
    .LEN_W   (LEN_W),
    .IDLE_BIT(IDLE_BIT)
  ) u_piso (
    .clock(clock),
    .reset(reset),
    .load (load),
    .shift(shift),
    .len  (load_len),
    .din  (load_pat),
    .dout (seq_out)
  );

endmodule

// File: doc/seq_gen_serial.md
Name: seq_gen_serial

Overview:
- Serial pattern transmitter. Drives a 1-bit stream into the serial sequence detectors (seq_det_101 and its successors), both in the testbenches and in the on-chip self-test path.
- Captures a programmable pattern of 1..PAT_W bits, shifts it out MSB-first at one bit per clock, and repeats it a programmable number of times.
- Uses a start/busy/done handshake toward the controlling logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, $clog2(PAT_W)+1, width of pat_len.
- CNT_W, 4, width of repeat_n (and of gap_n when the optional feature is compiled in).
- IDLE_BIT, 1'b0, level driven on seq_out when no bit is being sent.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send; sampled only in IDLE.
- pattern  input  PAT_W  bits to send; the active bits are pattern[pat_len-1:0].
- pat_len  input  LEN_W  number of active bits; valid range 1..PAT_W.
- repeat_n  input  CNT_W  extra repetitions; total sends = repeat_n+1.
- seq_out  output  1  serial data, registered.
- seq_valid  output  1  high when seq_out carries a pattern bit.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Clock and reset: one clock, clock. reset is synchronous and active-high. Every state change happens on the rising edge of clock.
- Reset values: state=IDLE, seq_out=IDLE_BIT, seq_valid=0, busy=0, done=0. All internal counters and the shift register are cleared.
- All outputs are registered; none is combinational from an input.
- FSM states are IDLE, SHIFT, GAP (only with the optional feature) and DONE.
- IDLE -> SHIFT: on an edge where start=1 and 1<=pat_len<=PAT_W.
  - pattern, pat_len and repeat_n are captured on that edge. Later input changes have no effect.
  - The first bit, pattern[pat_len-1], appears on seq_out with seq_valid=1 on that same edge. Latency from start to first bit is 1 cycle.
- IDLE with start=1 and pat_len=0 or pat_len>PAT_W: request ignored; FSM stays in IDLE.
- SHIFT: each cycle presents the next lower bit. The bit index counts down from pat_len-1 to 0.
- SHIFT after bit 0 with repetitions remaining (rep_left>0): rep_left is decremented, the index reloads to pat_len-1, and the next edge presents the first bit again. Repetitions are back-to-back with no bubble.
- SHIFT after bit 0 with rep_left=0: next state is DONE. seq_out=IDLE_BIT, seq_valid=0, done=1, busy=1.
- DONE -> IDLE: unconditionally after 1 cycle; done=0, busy=0.
- A start asserted during SHIFT, GAP or DONE is ignored. It is not queued.
- Minimum start-to-start spacing is pat_len*(repeat_n+1)+2 cycles.
- Maximum pattern length: pat_len=PAT_W is legal and sends the full vector.
- Maximum repeat count: repeat_n at its all-ones value gives 2^CNT_W sends.
- reset during SHIFT, GAP or DONE: the next edge returns to IDLE with the reset values. No done pulse is generated and the stream is truncated.

Optional Feature:
- Macro: SEQ_GEN_GAP_EN.
- Defined:
  - Adds input gap_n [CNT_W-1:0], captured at start.
  - Between repetitions the FSM enters GAP for gap_n cycles, driving seq_out=IDLE_BIT and seq_valid=0, then returns to SHIFT.
  - gap_n=0 behaves as back-to-back.
  - No GAP state is entered after the last repetition.
- Undefined: there is no gap_n port and no GAP state; repetitions are always back-to-back.

Decomposition:
- Package seq_pkg holds:
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, GAP=2'd2, DONE=2'd3;
  - the shared detector pattern constant PAT_101=3'b101 and its length 3.
- One sub-module, seq_piso: a PAT_W-bit parallel-load, MSB-first shift register with load, shift and len inputs.
- The FSM and the repetition/gap counters stay in seq_gen_serial.

Test Plan:
- Single send: pattern=8'h05, pat_len=3, repeat_n=0, start pulse.
  - seq_out=1,0,1 with seq_valid=1 on edges 1..3; done=1 on edge 4; busy=0 on edge 5.
  - Looped into seq_det_101: det_o=1 for exactly the cycle following the third bit.
- Repeat: same pattern with repeat_n=2.
  - Stream 101101101 over 9 consecutive valid cycles; single done on cycle 10.
  - Looped into seq_det_101: 3 det_o pulses.
- Full width: pattern=8'hA5, pat_len=8 -> stream 10100101, then done.
- Illegal start and start while busy:
  - pat_len=0 with start -> busy stays 0.
  - A second start mid-SHIFT -> no effect on the stream; exactly one done.
- Reset on edge 2 of an 8-bit send -> next edge gives seq_valid=0, busy=0, seq_out=IDLE_BIT; done never asserts.
- With SEQ_GEN_GAP_EN defined: pattern 101, repeat_n=1, gap_n=2 -> valid pattern 1,1,1,0,0,1,1,1 with data 1,0,1,-,-,1,0,1; done on cycle 9.
